fpu_op_scheduler: RTL and testbench

FPU_OP_SCHEDULER -- requirements
Module: fpu_op_scheduler

---
 rtl/fpu_op_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler
// Shares one fixed-latency add/mul datapath between two requesters (A and B).
// Each requester has a result FIFO of DEPTH entries. A credit counter per
// requester covers the ops it has in flight plus its FIFO occupancy, so a
// result always finds a free slot when it comes back.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   {a,b}_valid/ready        operation handshake (ready is combinational)
//   {a,b}_op, _x, _y         op (0 add, 1 mul) and IEEE-754 single operands
//   dp_valid/op/x/y          registered issue to the shared datapath
//   dp_r, dp_exc             datapath result, valid LAT cycles after dp_valid
//   {a,b}_rvalid/rready      result FIFO head handshake
//   {a,b}_r, _exc            result and exception flag at FIFO head
//   busy                     any op in flight or any FIFO non-empty
module fpu_op_scheduler #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_op,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_op,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    output logic        dp_valid,
    output logic        dp_op,
    output logic [31:0] dp_x,
    output logic [31:0] dp_y,
    input  logic [31:0] dp_r,
    input  logic        dp_exc,
    output logic        a_rvalid,
    input  logic        a_rready,
    output logic [31:0] a_r,
    output logic        a_exc,
    output logic        b_rvalid,
    input  logic        b_rready,
    output logic [31:0] b_r,
    output logic        b_exc,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Requester-indexed views: index 0 = A, index 1 = B.
    logic [1:0]       req_valid, req_op, rready;
    logic [1:0][31:0] req_x, req_y;
    logic [1:0]       elig, grant, push, pop, rvalid;
    logic             sel;

    logic             dp_valid_q, dp_valid_d, dp_op_q, dp_op_d, dp_own_q, dp_own_d;
    logic [31:0]      dp_x_q, dp_x_d, dp_y_q, dp_y_d;
    logic [LAT-1:0]   tag_v_q, tag_v_d, tag_own_q, tag_own_d;
    logic             ptr_q, ptr_d;
    logic [1:0][CW-1:0] credit_q, credit_d, cnt_q, cnt_d;
    logic [1:0][PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [1:0][DEPTH-1:0][32:0] mem_q, mem_d;

    assign req_valid = {b_valid, a_valid};
    assign req_op    = {b_op, a_op};
    assign req_x     = {b_x, a_x};
    assign req_y     = {b_y, a_y};
    assign rready    = {b_rready, a_rready};

    always_comb begin
        dp_valid_d = 1'b0;
        dp_op_d    = dp_op_q;
        dp_x_d     = dp_x_q;
        dp_y_d     = dp_y_q;
        dp_own_d   = dp_own_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        mem_d      = mem_q;
        elig       = '0;
        grant      = '0;
        push       = '0;
        pop        = '0;
        rvalid     = '0;
        tag_v_d    = '0;
        tag_own_d  = '0;

        // The issue register is the stage before the tag pipe, so the tag at
        // index LAT-1 lines up with the cycle dp_r is valid.
        tag_v_d[0]   = dp_valid_q;
        tag_own_d[0] = dp_own_q;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end

        for (int i = 0; i < 2; i++) begin
            elig[i]   = req_valid[i] && (credit_q[i] != '0) && !reset;
            rvalid[i] = (cnt_q[i] != '0);
            pop[i]    = rvalid[i] && rready[i];
            push[i]   = tag_v_q[LAT-1] && (tag_own_q[LAT-1] == i[0]);
        end

        grant[0] = elig[0] && (!elig[1] || !ptr_q);
        grant[1] = elig[1] && (!elig[0] ||  ptr_q);
        sel      = grant[1];

        if (grant != 2'b00) begin
            dp_valid_d = 1'b1;
            dp_own_d   = sel;
            dp_op_d    = req_op[sel];
            dp_x_d     = req_x[sel];
            dp_y_d     = req_y[sel];
            // Pointer names the requester that was not served.
            ptr_d      = grant[0];
        end

        for (int i = 0; i < 2; i++) begin
            case ({grant[i], pop[i]})
                2'b10:   credit_d[i] = credit_q[i] - CW'(1);
                2'b01:   credit_d[i] = credit_q[i] + CW'(1);
                default: credit_d[i] = credit_q[i];
            endcase
            if (push[i]) begin
                mem_d[i][wr_q[i]] = {dp_exc, dp_r};
                wr_d[i]           = wr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_d[i] = rd_q[i] + PW'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_valid_q <= 1'b0;
            dp_op_q    <= 1'b0;
            dp_x_q     <= '0;
            dp_y_q     <= '0;
            dp_own_q   <= 1'b0;
            tag_v_q    <= '0;
            tag_own_q  <= '0;
            ptr_q      <= 1'b0;
            credit_q   <= {2{CW'(DEPTH)}};
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            mem_q      <= '0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_op_q    <= dp_op_d;
            dp_x_q     <= dp_x_d;
            dp_y_q     <= dp_y_d;
            dp_own_q   <= dp_own_d;
            tag_v_q    <= tag_v_d;
            tag_own_q  <= tag_own_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            mem_q      <= mem_d;
        end
    end

    assign a_ready  = grant[0];
    assign b_ready  = grant[1];
    assign dp_valid = dp_valid_q;
    assign dp_op    = dp_op_q;
    assign dp_x     = dp_x_q;
    assign dp_y     = dp_y_q;

    // Heads are masked so an empty FIFO always presents zero.
    assign a_rvalid = rvalid[0];
    assign a_r      = rvalid[0] ? mem_q[0][rd_q[0]][31:0] : '0;
    assign a_exc    = rvalid[0] && mem_q[0][rd_q[0]][32];
    assign b_rvalid = rvalid[1];
    assign b_r      = rvalid[1] ? mem_q[1][rd_q[1]][31:0] : '0;
    assign b_exc    = rvalid[1] && mem_q[1][rd_q[1]][32];

    assign busy = dp_valid_q || (tag_v_q != '0) || (rvalid != 2'b00);
endmodule

// File: tb/tb_fpu_op_scheduler.sv
module tb_fpu_op_scheduler;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, a_op = 1'b0, b_op = 1'b0;
    logic [31:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
    logic        a_rready = 1'b0, b_rready = 1'b0;
    logic        a_ready, b_ready, dp_valid, dp_op;
    logic [31:0] dp_x, dp_y, dp_r;
    logic        dp_exc;
    logic        a_rvalid, a_exc, b_rvalid, b_exc, busy;
    logic [31:0] a_r, b_r;

    int checks = 0;
    int errors = 0;

    fpu_op_scheduler #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
        .dp_valid(dp_valid), .dp_op(dp_op), .dp_x(dp_x), .dp_y(dp_y),
        .dp_r(dp_r), .dp_exc(dp_exc),
        .a_rvalid(a_rvalid), .a_rready(a_rready), .a_r(a_r), .a_exc(a_exc),
        .b_rvalid(b_rvalid), .b_rready(b_rready), .b_r(b_r), .b_exc(b_exc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Stand-in datapath arithmetic: only routing and ordering matter here, so
    // one known IEEE sum is exact and everything else is a cheap mix.
    // The exception flag follows y[0] so tests can request it.
    function automatic logic [32:0] dp_fn(input logic op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        if (!op && x == 32'h3F80_0000 && y == 32'h4000_0000) r = 32'h4040_0000;
        else if (op) r = x ^ {y[15:0], y[31:16]};
        else r = x + y;
        return {y[0], r};
    endfunction

    // Datapath model: result appears LAT cycles after dp_valid; junk otherwise.
    logic [65:0] pipe [0:LAT] = '{default: '0};
    always @(negedge clk) begin
        for (int k = LAT; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = {dp_valid, dp_op, dp_x, dp_y};
        if (pipe[LAT][65]) {dp_exc, dp_r} = dp_fn(pipe[LAT][64], pipe[LAT][63:32], pipe[LAT][31:0]);
        else begin
            dp_r   = $urandom;
            dp_exc = 1'($urandom);
        end
    end

    // Scoreboard plus arbitration/credit model. Queue size = in-flight + FIFO.
    logic [32:0] qa[$], qb[$];
    logic        ptr_m = 1'b0;
    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic [32:0] held_a, held_b;
    int          exc_a_seen = 0, exc_b_seen = 0;

    always @(negedge clk) begin
        logic ea, eb, xa, xb;
        logic [32:0] exp_v;
        if (reset) begin
            chk("ready_in_reset", {a_ready, b_ready}, 2'b00);
            qa.delete();
            qb.delete();
            ptr_m  = 1'b0;
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            ea = a_valid && (qa.size() < DEPTH);
            eb = b_valid && (qb.size() < DEPTH);
            xa = ea && (!eb || !ptr_m);
            xb = eb && (!ea || ptr_m);
            chk("a_ready_model", a_ready, xa);
            chk("b_ready_model", b_ready, xb);
            if (xa || xb) ptr_m = xa;
            if (a_valid && a_ready) qa.push_back(dp_fn(a_op, a_x, a_y));
            if (b_valid && b_ready) qb.push_back(dp_fn(b_op, b_x, b_y));

            if (hold_a) chk("a_head_stable", {a_exc, a_r}, held_a);
            if (hold_b) chk("b_head_stable", {b_exc, b_r}, held_b);
            hold_a = a_rvalid && !a_rready;
            held_a = {a_exc, a_r};
            hold_b = b_rvalid && !b_rready;
            held_b = {b_exc, b_r};

            if (a_rvalid && a_rready) begin
                chk("a_pop_expected", qa.size() != 0, 1'b1);
                if (qa.size() != 0) begin
                    exp_v = qa.pop_front();
                    chk("a_result", {a_exc, a_r}, exp_v);
                end
                if (a_exc) exc_a_seen++;
            end
            if (b_rvalid && b_rready) begin
                chk("b_pop_expected", qb.size() != 0, 1'b1);
                if (qb.size() != 0) begin
                    exp_v = qb.pop_front();
                    chk("b_result", {b_exc, b_r}, exp_v);
                end
                if (b_exc) exc_b_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_rready = 1'b1;
        b_rready = 1'b1;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk({name, "_drained"}, busy, 1'b0);
        chk({name, "_queues_empty"}, qa.size() + qb.size(), 0);
    endtask

    typedef struct {
        logic av;
        logic bv;
        logic ra;
        logic rb;
    } arb_vec_t;
    arb_vec_t tbl [10];

    initial begin
        int n, co, nbexc, sa, sb;

        tbl[0] = '{av: 1'b1, bv: 1'b1, ra: 1'b1, rb: 1'b0};
        tbl[1] = '{av: 1'b1, bv: 1'b1, ra: 1'b0, rb: 1'b1};
        tbl[2] = '{av: 1'b1, bv: 1'b1, ra: 1'b1, rb: 1'b0};
        tbl[3] = '{av: 1'b0, bv: 1'b1, ra: 1'b0, rb: 1'b1};
        tbl[4] = '{av: 1'b0, bv: 1'b1, ra: 1'b0, rb: 1'b1};
        tbl[5] = '{av: 1'b1, bv: 1'b1, ra: 1'b1, rb: 1'b0};
        tbl[6] = '{av: 1'b1, bv: 1'b0, ra: 1'b1, rb: 1'b0};
        tbl[7] = '{av: 1'b1, bv: 1'b1, ra: 1'b0, rb: 1'b1};
        tbl[8] = '{av: 1'b0, bv: 1'b0, ra: 1'b0, rb: 1'b0};
        tbl[9] = '{av: 1'b1, bv: 1'b1, ra: 1'b1, rb: 1'b0};

        // Single add: issue, latency and result.
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        a_valid = 1'b1; a_op = 1'b0; a_x = 32'h3F80_0000; a_y = 32'h4000_0000;
        #1;
        chk("single_a_ready", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        chk("single_dp_valid", dp_valid, 1'b1);
        chk("single_dp_op", dp_op, 1'b0);
        chk("single_dp_x", dp_x, 32'h3F80_0000);
        chk("single_dp_y", dp_y, 32'h4000_0000);
        step();
        chk("single_dp_idle", dp_valid, 1'b0);
        chk("single_dp_x_hold", dp_x, 32'h3F80_0000);
        for (int i = 0; i < 4; i++) begin
            chk("single_early_rvalid", a_rvalid, 1'b0);
            if (i < 3) step();
        end
        step();
        chk("single_rvalid", a_rvalid, 1'b1);
        chk("single_r", a_r, 32'h4040_0000);
        chk("single_exc", a_exc, 1'b0);
        a_rready = 1'b1;
        step();
        a_rready = 1'b0;
        chk("single_busy_after", busy, 1'b0);

        // Round-robin table with both consumers always ready.
        do_reset();
        a_rready = 1'b1;
        b_rready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_valid = tbl[i].av; b_valid = tbl[i].bv;
            a_op = 32'(i) % 2 == 0; b_op = !a_op;
            a_x = 32'hA000_0000 + 32'(i); a_y = 32'(i) << 1;
            b_x = 32'hB000_0000 + 32'(i); b_y = (32'(i) << 1) + 32'd64;
            #1;
            chk("arb_a_ready", a_ready, tbl[i].ra);
            chk("arb_b_ready", b_ready, tbl[i].rb);
            step();
        end
        drain("arb");

        // Credit limit with a stalled consumer, then a single pop.
        do_reset();
        a_rready = 1'b0;
        b_rready = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1; a_op = 1'b1; a_x = 32'h100 + 32'(i); a_y = 32'(i) << 1;
            #1;
            if (a_ready) n++;
            step();
        end
        chk("credit_handshakes", n, 4);
        #1;
        chk("credit_exhausted_ready", a_ready, 1'b0);
        a_rready = 1'b1;
        step();
        a_rready = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            a_x = 32'h200 + 32'(i); a_y = 32'(i) << 1;
            #1;
            if (a_ready) n++;
            step();
        end
        chk("credit_after_pulse", n, 1);

        // Pop and handshake on the same requester in the same cycle.
        a_rready = 1'b1;
        co = 0;
        for (int i = 0; i < 12; i++) begin
            a_x = 32'h300 + 32'(i); a_y = 32'(i) << 1;
            #1;
            if (a_ready && a_rvalid && a_rready) co++;
            step();
        end
        chk("pop_and_issue_same_cycle", co != 0, 1'b1);
        drain("credit");

        // Reset two cycles after an issue drops the late result.
        do_reset();
        a_valid = 1'b1; a_op = 1'b0; a_x = 32'h1234_5678; a_y = 32'h0000_0010;
        a_rready = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_dp_valid", dp_valid, 1'b0);
        chk("rstmid_dp_x", dp_x, 32'h0);
        chk("rstmid_dp_y", dp_y, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("rstmid_busy", busy, 1'b0);
            chk("rstmid_rvalid", a_rvalid, 1'b0);
            chk("rstmid_r", a_r, 32'h0);
            step();
        end

        // Exception flags on some B results only.
        do_reset();
        a_rready = 1'b1;
        b_rready = 1'b1;
        nbexc = 0;
        sa = exc_a_seen;
        sb = exc_b_seen;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; b_valid = 1'b1; a_op = 1'b0; b_op = 1'b1;
            a_x = 32'hC000_0000 + 32'(i); a_y = 32'(i) << 1;
            b_x = 32'hD000_0000 + 32'(i);
            b_y = (i % 3 == 0) ? ((32'(i) << 1) | 32'd1) : (32'(i) << 1);
            #1;
            if (b_ready && b_y[0]) nbexc++;
            step();
        end
        drain("exc");
        chk("exc_a_none", exc_a_seen - sa, 0);
        chk("exc_b_count", exc_b_seen - sb, nbexc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
